// File: rtl/conv_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_sequencer
// Purpose  : Collects weight and pixel beats from one stream into two K*K
//            operand banks. Starts the accelerator lanes, waits for the
//            accumulated sum and returns it on a valid/ready result port.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int KERNEL_SIZE   = 3,
  parameter int AXI_BUS_WIDTH = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                                               Clk,
  input  logic                                               Rst,
  input  logic [AXI_BUS_WIDTH-1:0]                           s_data,
  input  logic                                               s_weight,
  input  logic                                               s_valid,
  output logic                                               s_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*AXI_BUS_WIDTH-1:0]   multiplier_input,
  output logic [KERNEL_SIZE*KERNEL_SIZE*AXI_BUS_WIDTH-1:0]   multiplicand_input,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]                 mStart,
  input  logic [AXI_BUS_WIDTH-1:0]                           finalAccumulate,
  input  logic                                               finalReady,
  output logic [AXI_BUS_WIDTH-1:0]                           r_data,
  output logic                                               r_valid,
  input  logic                                               r_ready,
  output logic                                               weights_loaded,
  output logic [15:0]                                        window_count
);

  localparam int N      = KERNEL_SIZE * KERNEL_SIZE;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  // An operand occupies the low DATA_WIDTH bits of its lane slot.
  localparam int LANE_W = (DATA_WIDTH < AXI_BUS_WIDTH) ? DATA_WIDTH : AXI_BUS_WIDTH;

  localparam logic [IDX_W-1:0] LAST_LANE   = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic [2:0] ST_LOAD   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_OUT    = 3'd4;

  logic [2:0]               state;
  logic [2:0]               state_next;
  logic [IDX_W-1:0]         w_idx;
  logic [IDX_W-1:0]         p_idx;
  logic [CNT_W-1:0]         settle_cnt;
  logic [15:0]              win_cnt;
  logic [AXI_BUS_WIDTH-1:0] beat_operand;
  logic                     weight_take;
  logic                     pixel_take;
  logic                     last_pixel;

  assign weight_take  = s_valid && s_ready && s_weight;
  assign pixel_take   = s_valid && s_ready && !s_weight;
  assign last_pixel   = pixel_take && (p_idx == LAST_LANE);
  assign window_count = win_cnt;

  // Place the operand bits of the incoming beat into a lane-wide word.
  always_comb begin
    beat_operand               = '0;
    beat_operand[LANE_W-1:0]   = s_data[LANE_W-1:0];
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; finalReady is only looked at once SETTLE has elapsed.
  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD:   if (last_pixel) state_next = ST_START;
      ST_START:  state_next = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_next = ST_WAIT;
      ST_WAIT:   if (finalReady) state_next = ST_OUT;
      ST_OUT:    if (r_ready) state_next = ST_LOAD;
      default:   state_next = ST_LOAD;
    endcase
  end

  // Outputs decoded from state; pixels are refused until a full weight set exists.
  always_comb begin
    s_ready = 1'b0;
    mStart  = '0;
    r_valid = 1'b0;
    case (state)
      ST_LOAD:  s_ready = !Rst && (s_weight || weights_loaded);
      ST_START: mStart  = '1;
      ST_OUT:   r_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand banks and lane indices; banks only move on accepted beats.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      multiplier_input   <= '0;
      multiplicand_input <= '0;
      w_idx              <= '0;
      p_idx              <= '0;
      weights_loaded     <= 1'b0;
    end else begin
      if (weight_take) begin
        multiplicand_input[int'(w_idx)*AXI_BUS_WIDTH +: AXI_BUS_WIDTH] <= beat_operand;
        if (w_idx == LAST_LANE) begin
          w_idx          <= '0;
          weights_loaded <= 1'b1;
        end else begin
          w_idx <= w_idx + 1'b1;
        end
      end
      if (pixel_take) begin
        multiplier_input[int'(p_idx)*AXI_BUS_WIDTH +: AXI_BUS_WIDTH] <= beat_operand;
        if (p_idx == LAST_LANE) begin
          p_idx <= '0;
        end else begin
          p_idx <= p_idx + 1'b1;
        end
      end
    end
  end

  // Settle counter runs only while in SETTLE and restarts from zero each window.
  always_ff @(posedge Clk) begin
    if (Rst || (state != ST_SETTLE)) begin
      settle_cnt <= '0;
    end else begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // Result capture and delivered-window counter.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_data  <= '0;
      win_cnt <= '0;
    end else begin
      if ((state == ST_WAIT) && finalReady) begin
        r_data <= finalAccumulate;
      end
      if ((state == ST_OUT) && r_ready) begin
        win_cnt <= win_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire
